// File: rtl/sd_cmd_phy_if.sv
// sd_cmd_phy_if: controller-side command/response handshake of the SD CMD-line PHY.
// The controller uses the master modport, the PHY uses the slave modport.
interface sd_cmd_phy_if;
    logic [39:0] cmd_in;
    logic        strobe_in;
    logic        ack_in;
    logic [39:0] cmd_out;
    logic        strobe_out;
    logic        ack_out;
    logic        serial_ready;
    logic        crc_error;
    logic        resp_timeout;

    modport master (
        output cmd_in, strobe_in, ack_in,
        input  cmd_out, strobe_out, ack_out, serial_ready, crc_error, resp_timeout
    );

    modport slave (
        input  cmd_in, strobe_in, ack_in,
        output cmd_out, strobe_out, ack_out, serial_ready, crc_error, resp_timeout
    );
endinterface

// File: rtl/sd_cmd_phy.sv
// sd_cmd_phy: SD CMD-line PHY; serialises command frames with CRC7 and captures/checks the response.
// Optional macro SD_CMD_PHY_NORESP_EN: CMD0 (index 0) skips the response phase.
module sd_cmd_phy #(
    parameter int RESP_TIMEOUT = 64,
    parameter int CNT_W        = 8
) (
    input  logic        clock,
    input  logic        reset,
    sd_cmd_phy_if.slave ctrl,
    input  logic        cmd_pin_in,
    output logic        cmd_pin_out,
    output logic        cmd_pin_oe
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SEND      = 3'd1;
    localparam logic [2:0] WAIT_RESP = 3'd2;
    localparam logic [2:0] RECEIVE   = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RESP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WAIT_MAX  = CNT_W'(RESP_TIMEOUT);

    logic [2:0]       state_q, state_d;
    logic [47:0]      shift_q, shift_d;
    logic [5:0]       bitCnt_q, bitCnt_d;
    logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
    logic [6:0]       crc_q, crc_d;
    logic             strobePrev_q;
    logic [39:0]      cmdOut_q, cmdOut_d;
    logic             strobeOut_q, strobeOut_d;
    logic             ackOut_q, ackOut_d;
    logic             ready_q, ready_d;
    logic             pinOut_q, pinOut_d;
    logic             pinOe_q, pinOe_d;
    logic             crcError_q, crcError_d;
    logic             respTimeout_q, respTimeout_d;
`ifdef SD_CMD_PHY_NORESP_EN
    logic             noResp_q, noResp_d;
`endif

    function automatic logic [6:0] crc7Next(input logic [6:0] crc, input logic bitIn);
        logic fb;
        fb = bitIn ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // bitCnt is the index of the bit on the pin while sending, and the bits still expected while receiving
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bitCnt_d      = bitCnt_q;
        waitCnt_d     = waitCnt_q;
        crc_d         = crc_q;
        cmdOut_d      = cmdOut_q;
        strobeOut_d   = strobeOut_q;
        crcError_d    = crcError_q;
        ackOut_d      = 1'b0;
        respTimeout_d = 1'b0;
        pinOut_d      = 1'b1;
        pinOe_d       = 1'b0;
`ifdef SD_CMD_PHY_NORESP_EN
        noResp_d      = noResp_q;
`endif
        case (state_q)
            IDLE: begin
                if (ctrl.strobe_in && !strobePrev_q && !ctrl.ack_in) begin
                    state_d  = SEND;
                    shift_d  = {ctrl.cmd_in[38:0], 9'h000};
                    crc_d    = crc7Next(7'h00, ctrl.cmd_in[39]);
                    bitCnt_d = 6'd47;
                    pinOut_d = ctrl.cmd_in[39];
                    pinOe_d  = 1'b1;
`ifdef SD_CMD_PHY_NORESP_EN
                    noResp_d = (ctrl.cmd_in[37:32] == 6'd0);
`endif
                end
            end
            SEND: begin
                if (bitCnt_q == 6'd0) begin
                    waitCnt_d = '0;
                    crc_d     = 7'h00;
`ifdef SD_CMD_PHY_NORESP_EN
                    if (noResp_q) begin
                        state_d     = DONE;
                        cmdOut_d    = '0;
                        crcError_d  = 1'b0;
                        strobeOut_d = 1'b1;
                    end else begin
                        state_d = WAIT_RESP;
                    end
`else
                    state_d = WAIT_RESP;
`endif
                end else begin
                    bitCnt_d = bitCnt_q - 6'd1;
                    pinOe_d  = 1'b1;
                    if (bitCnt_q > 6'd8) begin
                        pinOut_d = shift_q[47];
                        shift_d  = {shift_q[46:0], 1'b0};
                        crc_d    = crc7Next(crc_q, shift_q[47]);
                    end else if (bitCnt_q > 6'd1) begin
                        pinOut_d = crc_q[6];
                        crc_d    = {crc_q[5:0], 1'b0};
                    end
                end
            end
            WAIT_RESP: begin
                if (!cmd_pin_in) begin
                    state_d  = RECEIVE;
                    shift_d  = '0;
                    crc_d    = 7'h00;
                    bitCnt_d = 6'd47;
                end else if (waitCnt_q >= WAIT_LAST) begin
                    state_d       = IDLE;
                    waitCnt_d     = WAIT_MAX;
                    respTimeout_d = 1'b1;
                    cmdOut_d      = '0;
                end else begin
                    waitCnt_d = waitCnt_q + CNT_W'(1);
                end
            end
            RECEIVE: begin
                shift_d = {shift_q[46:0], cmd_pin_in};
                if (bitCnt_q > 6'd8) begin
                    crc_d = crc7Next(crc_q, cmd_pin_in);
                end
                if (bitCnt_q <= 6'd1) begin
                    state_d     = DONE;
                    bitCnt_d    = 6'd0;
                    cmdOut_d    = shift_q[46:7];
                    crcError_d  = (crc_q != shift_q[6:0]) || !cmd_pin_in;
                    strobeOut_d = 1'b1;
                end else begin
                    bitCnt_d = bitCnt_q - 6'd1;
                end
            end
            DONE: begin
                if (ctrl.ack_in) begin
                    state_d     = IDLE;
                    strobeOut_d = 1'b0;
                    ackOut_d    = 1'b1;
                    crcError_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            bitCnt_q      <= '0;
            waitCnt_q     <= '0;
            crc_q         <= '0;
            strobePrev_q  <= 1'b0;
            cmdOut_q      <= '0;
            strobeOut_q   <= 1'b0;
            ackOut_q      <= 1'b0;
            ready_q       <= 1'b1;
            pinOut_q      <= 1'b1;
            pinOe_q       <= 1'b0;
            crcError_q    <= 1'b0;
            respTimeout_q <= 1'b0;
`ifdef SD_CMD_PHY_NORESP_EN
            noResp_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bitCnt_q      <= bitCnt_d;
            waitCnt_q     <= waitCnt_d;
            crc_q         <= crc_d;
            strobePrev_q  <= ctrl.strobe_in;
            cmdOut_q      <= cmdOut_d;
            strobeOut_q   <= strobeOut_d;
            ackOut_q      <= ackOut_d;
            ready_q       <= ready_d;
            pinOut_q      <= pinOut_d;
            pinOe_q       <= pinOe_d;
            crcError_q    <= crcError_d;
            respTimeout_q <= respTimeout_d;
`ifdef SD_CMD_PHY_NORESP_EN
            noResp_q      <= noResp_d;
`endif
        end
    end

    assign ctrl.cmd_out      = cmdOut_q;
    assign ctrl.strobe_out   = strobeOut_q;
    assign ctrl.ack_out      = ackOut_q;
    assign ctrl.serial_ready = ready_q;
    assign ctrl.crc_error    = crcError_q;
    assign ctrl.resp_timeout = respTimeout_q;
    assign cmd_pin_out       = pinOut_q;
    assign cmd_pin_oe        = pinOe_q;

endmodule

// File: tb/tb_sd_cmd_phy.sv
// tb_sd_cmd_phy: directed self-checking bench for sd_cmd_phy (frames, responses, CRC fault, timeout, reset).
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_sd_cmd_phy;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic cmdPinIn = 1'b1;
    logic cmdPinOut;
    logic cmdPinOe;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    sd_cmd_phy_if ctrlIf();

    sd_cmd_phy #(.RESP_TIMEOUT(64), .CNT_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .ctrl       (ctrlIf),
        .cmd_pin_in (cmdPinIn),
        .cmd_pin_out(cmdPinOut),
        .cmd_pin_oe (cmdPinOe)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [47:0] observed, input logic [47:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [39:0] cmd);
        ctrlIf.cmd_in    = cmd;
        ctrlIf.strobe_in = 1'b1;
    endtask

    // Collects pin bits while oe is high; returns at the first falling edge with oe low again
    task automatic collectFrame(output logic [47:0] frame, output int bits, output int readySeen);
        frame = '0;
        bits = 0;
        readySeen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (cmdPinOe) begin
                frame = {frame[46:0], cmdPinOut};
                bits++;
                if (ctrlIf.serial_ready) readySeen++;
            end else if (bits > 0) begin
                break;
            end
        end
    endtask

    task automatic sendResponse(input logic [47:0] resp);
        repeat (5) @(negedge clock);
        for (int i = 47; i >= 0; i--) begin
            cmdPinIn = resp[i];
            @(negedge clock);
        end
        cmdPinIn = 1'b1;
    endtask

    // Entered on the first falling edge after oe dropped; the pulse should appear 64 edges later
    task automatic waitTimeout(input string tag);
        int k;
        int strobeSeen;
        k = 0;
        strobeSeen = 0;
        while (k < 100 && !ctrlIf.resp_timeout) begin
            if (ctrlIf.strobe_out) strobeSeen++;
            @(negedge clock);
            k++;
        end
        checkOutput({tag, "_latency"}, 48'(k), 48'd64);
        checkOutput({tag, "_no_strobe"}, 48'(strobeSeen), 48'd0);
        @(negedge clock);
        checkOutput({tag, "_pulse_width"}, 48'(ctrlIf.resp_timeout), 48'd0);
        checkOutput({tag, "_ready"}, 48'(ctrlIf.serial_ready), 48'd1);
        checkOutput({tag, "_cmd_out"}, 48'(ctrlIf.cmd_out), 48'd0);
    endtask

    task automatic doAck(input string tag);
        ctrlIf.ack_in = 1'b1;
        @(negedge clock);
        checkOutput({tag, "_ack_out"}, 48'(ctrlIf.ack_out), 48'd1);
        checkOutput({tag, "_strobe_low"}, 48'(ctrlIf.strobe_out), 48'd0);
        checkOutput({tag, "_ready"}, 48'(ctrlIf.serial_ready), 48'd1);
        checkOutput({tag, "_crc_clear"}, 48'(ctrlIf.crc_error), 48'd0);
        ctrlIf.ack_in = 1'b0;
        @(negedge clock);
        checkOutput({tag, "_ack_pulse"}, 48'(ctrlIf.ack_out), 48'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [47:0] frame;
        int bits;
        int readySeen;
        int seen;
        int oeSeen;

        ctrlIf.cmd_in    = '0;
        ctrlIf.strobe_in = 1'b0;
        ctrlIf.ack_in    = 1'b0;
        repeat (3) @(negedge clock);

        checkOutput("rst_cmd_out", 48'(ctrlIf.cmd_out), 48'd0);
        checkOutput("rst_strobe_out", 48'(ctrlIf.strobe_out), 48'd0);
        checkOutput("rst_ack_out", 48'(ctrlIf.ack_out), 48'd0);
        checkOutput("rst_ready", 48'(ctrlIf.serial_ready), 48'd1);
        checkOutput("rst_pin_out", 48'(cmdPinOut), 48'd1);
        checkOutput("rst_oe", 48'(cmdPinOe), 48'd0);
        checkOutput("rst_crc_error", 48'(ctrlIf.crc_error), 48'd0);
        checkOutput("rst_timeout", 48'(ctrlIf.resp_timeout), 48'd0);
        reset = 1'b0;
        @(negedge clock);

        // CMD0 frame
        applyStimulus(40'h4000000000);
        collectFrame(frame, bits, readySeen);
        checkOutput("cmd0_frame", frame, 48'h400000000095);
        checkOutput("cmd0_oe_cycles", 48'(bits), 48'd48);
        checkOutput("cmd0_ready_in_send", 48'(readySeen), 48'd0);
        checkOutput("cmd0_pin_released", 48'(cmdPinOut), 48'd1);
`ifdef SD_CMD_PHY_NORESP_EN
        checkOutput("cmd0_noresp_strobe", 48'(ctrlIf.strobe_out), 48'd1);
        checkOutput("cmd0_noresp_cmd_out", 48'(ctrlIf.cmd_out), 48'd0);
        checkOutput("cmd0_noresp_crc", 48'(ctrlIf.crc_error), 48'd0);
        ctrlIf.strobe_in = 1'b0;
        doAck("cmd0");
`else
        waitTimeout("cmd0_timeout");
        ctrlIf.strobe_in = 1'b0;
        @(negedge clock);
`endif

        // CMD8 with a clean response
        applyStimulus(40'h48000001AA);
        collectFrame(frame, bits, readySeen);
        checkOutput("cmd8_frame", frame, 48'h48000001AA87);
        checkOutput("cmd8_oe_cycles", 48'(bits), 48'd48);
        sendResponse(48'h08000001AA13);
        checkOutput("cmd8_strobe", 48'(ctrlIf.strobe_out), 48'd1);
        checkOutput("cmd8_cmd_out", 48'(ctrlIf.cmd_out), 48'h08000001AA);
        checkOutput("cmd8_crc_ok", 48'(ctrlIf.crc_error), 48'd0);
        checkOutput("cmd8_not_ready", 48'(ctrlIf.serial_ready), 48'd0);
        repeat (3) @(negedge clock);
        checkOutput("cmd8_strobe_held", 48'(ctrlIf.strobe_out), 48'd1);
        checkOutput("cmd8_cmd_out_held", 48'(ctrlIf.cmd_out), 48'h08000001AA);
        ctrlIf.strobe_in = 1'b0;
        doAck("cmd8");

        // CMD8 with a corrupted CRC in the response
        applyStimulus(40'h48000001AA);
        collectFrame(frame, bits, readySeen);
        checkOutput("crcf_frame", frame, 48'h48000001AA87);
        sendResponse(48'h08000001AA15);
        checkOutput("crcf_strobe", 48'(ctrlIf.strobe_out), 48'd1);
        checkOutput("crcf_crc_error", 48'(ctrlIf.crc_error), 48'd1);
        checkOutput("crcf_cmd_out", 48'(ctrlIf.cmd_out), 48'h08000001AA);
        ctrlIf.strobe_in = 1'b0;
        doAck("crcf");

        // Timeout with strobe_in held high: no re-trigger until it drops
        applyStimulus(40'h48000001AA);
        collectFrame(frame, bits, readySeen);
        checkOutput("tmo_frame", frame, 48'h48000001AA87);
        waitTimeout("tmo");
        oeSeen = 0;
        repeat (4) begin
            @(negedge clock);
            if (cmdPinOe) oeSeen++;
        end
        checkOutput("retrigger_blocked", 48'(oeSeen), 48'd0);
        checkOutput("retrigger_ready", 48'(ctrlIf.serial_ready), 48'd1);
        ctrlIf.strobe_in = 1'b0;
        @(negedge clock);

        // Reset in the middle of SEND, then a fresh full frame
        applyStimulus(40'h48000001AA);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (cmdPinOe) seen++;
            if (seen == 20) break;
        end
        checkOutput("midrst_bits_before", 48'(seen), 48'd20);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midrst_oe", 48'(cmdPinOe), 48'd0);
        checkOutput("midrst_pin_out", 48'(cmdPinOut), 48'd1);
        checkOutput("midrst_ready", 48'(ctrlIf.serial_ready), 48'd1);
        checkOutput("midrst_strobe_out", 48'(ctrlIf.strobe_out), 48'd0);
        checkOutput("midrst_ack_out", 48'(ctrlIf.ack_out), 48'd0);
        checkOutput("midrst_cmd_out", 48'(ctrlIf.cmd_out), 48'd0);
        reset = 1'b0;
        ctrlIf.strobe_in = 1'b0;
        @(negedge clock);
        applyStimulus(40'h48000001AA);
        collectFrame(frame, bits, readySeen);
        checkOutput("postrst_frame", frame, 48'h48000001AA87);
        checkOutput("postrst_oe_cycles", 48'(bits), 48'd48);
        ctrlIf.strobe_in = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/sd_cmd_phy.md
Name: sd_cmd_phy

Overview:
- Serial command physical layer for the SD host. It sits directly downstream of the host command controller.
- Takes the 40-bit command word {start, transmission, index[5:0], argument[31:0]} plus a strobe. Appends CRC7 and an end bit, then shifts the 48-bit frame out on the CMD pin MSB-first, one bit per clock.
- Captures the 48-bit response from the pin, checks its CRC7, and returns the 40-bit response word to the controller through a strobe/ack handshake.

Parameters:
- RESP_TIMEOUT, 64, maximum number of clocks in WAIT_RESP without seeing a start bit before aborting.
- CNT_W, 8, width of the response-wait counter; must satisfy 2^CNT_W > RESP_TIMEOUT.

Ports:
- clock  in  1  block clock; also the SD CMD bit clock.
- reset  in  1  synchronous, active-high.
- cmd_in  in  40  command word from the controller: [39:38] start/transmission bits, [37:32] index, [31:0] argument.
- strobe_in  in  1  controller has a valid command on cmd_in and holds it until done.
- ack_in  in  1  controller accepts the response presented on cmd_out.
- cmd_pin_in  in  1  CMD line sampled value.
- cmd_out  out  40  received response bits [47:8].
- strobe_out  out  1  response valid on cmd_out.
- ack_out  out  1  one-cycle pulse ending the transaction.
- serial_ready  out  1  block is in IDLE and can accept a command.
- cmd_pin_out  out  1  CMD line drive value.
- cmd_pin_oe  out  1  CMD line output enable.
- crc_error  out  1  response CRC7 or end-bit mismatch, held with strobe_out.
- resp_timeout  out  1  one-cycle pulse when no response arrived.

Behaviour:
- Interface: reset is synchronous, active-high, named reset; clock is clock. All outputs are registered.
- Reset values: cmd_out=0, strobe_out=0, ack_out=0, serial_ready=1, cmd_pin_out=1, cmd_pin_oe=0, crc_error=0, resp_timeout=0. State=IDLE; bit counter, wait counter and CRC register are 0.
- Reset mid-operation aborts immediately. oe drops and the line is released at the next edge.
- States: IDLE, SEND, WAIT_RESP, RECEIVE, DONE.
- IDLE:
  - serial_ready=1, oe=0, pin_out=1.
  - On strobe_in=1 and ack_in=0, latch cmd_in into the shift register, clear CRC, and go to SEND.
- SEND:
  - oe=1 for exactly 48 consecutive cycles; serial_ready=0.
  - Bit 47 (cmd_in[39]) is driven in the first SEND cycle.
  - Frame bits 47..8 are the latched cmd_in[39:0]. CRC7 (polynomial x^7+x^3+1, init 0) is updated on each of these 40 bits.
  - Bits 7..1 are CRC[6:0], MSB first. Bit 0 is 1.
  - After the 48th bit go to WAIT_RESP with oe=0 and the wait counter cleared.
- WAIT_RESP:
  - Sample cmd_pin_in every clock. The first 0 is response bit 47; store it and go to RECEIVE with 47 bits remaining.
  - If the counter reaches RESP_TIMEOUT: pulse resp_timeout for 1 cycle, keep cmd_out=0, go to IDLE. No strobe_out.
- RECEIVE:
  - Shift in 47 more bits MSB-first while computing CRC7 over bits 47..8.
  - After bit 0: cmd_out = bits[47:8]. crc_error = (computed CRC != bits[7:1]) OR (bit0 != 1). strobe_out=1. Go to DONE.
- DONE:
  - Hold cmd_out, crc_error and strobe_out=1 until ack_in=1.
  - On ack_in=1 in DONE: strobe_out=0, ack_out=1 for exactly one cycle, crc_error cleared, go to IDLE.
- Re-triggering: strobe_in still high on return to IDLE does not start a new frame until strobe_in has been seen low at least one cycle (edge-qualified via a registered strobe_in).
- ack_in outside DONE is ignored. strobe_in changes outside IDLE are ignored.
- Counters: the bit counter is 6 bits and never wraps past 47. The wait counter saturates at RESP_TIMEOUT.

Optional Feature:
- Macro: SD_CMD_PHY_NORESP_EN.
- Defined: a command with index cmd_in[37:32]==0 (CMD0, no response) skips WAIT_RESP/RECEIVE. After SEND the block goes to DONE with cmd_out=40'h0000000000, crc_error=0, strobe_out=1, and the normal ack handshake follows.
- Undefined: every command waits for a response. CMD0 therefore ends in resp_timeout after RESP_TIMEOUT clocks.

Test Plan:
- CMD0: cmd_in=40'h4000000000, strobe_in=1 → cmd_pin_oe=1 for 48 cycles; serialized frame equals 48'h400000000095 (CRC 0x4A, end 1); then oe=0.
- CMD8: cmd_in=40'h48000001AA → frame 48'h48000001AA87. Bench drives response 48'h08000001AA13 after a 5-cycle gap → strobe_out=1, cmd_out=40'h08000001AA, crc_error=0; ack_in pulse → ack_out pulses 1 cycle, serial_ready=1 next cycle.
- CRC fault: as in the CMD8 case but the response is 48'h08000001AA15 → strobe_out=1, crc_error=1, cmd_out=40'h08000001AA.
- Timeout: send CMD8 and hold cmd_pin_in=1 → resp_timeout pulses exactly RESP_TIMEOUT (64) cycles after the last frame bit; strobe_out never asserts; block returns to IDLE.
- Reset mid-SEND: assert reset at bit 20 → next edge oe=0, pin_out=1, serial_ready=1, all outputs at reset values. A new strobe_in then produces a full, correct 48-bit frame.
- SD_CMD_PHY_NORESP_EN: CMD0 with the macro defined → strobe_out within 1 cycle after the 48th bit, cmd_out=0. Without the macro → resp_timeout after 64 idle cycles.
